// File: rtl/priority_pkg.sv
// Shared defaults and the index-to-one-hot mapping for the priority decoder.
// Bit 0 of the one-hot vector is the highest-priority request line, so
// index WIDTH-1 maps to bit 0 and index 0 maps to the top bit.
package priority_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_IDX_W = $clog2(DEF_WIDTH);
   localparam int DEF_DEPTH = 4;

   // Reference mapping: out = 1 << (WIDTH-1-idx)
   function automatic logic [DEF_WIDTH-1:0] idx_to_onehot(input logic [DEF_IDX_W-1:0] idx);
      logic [DEF_WIDTH-1:0] vec;
      vec = {DEF_WIDTH{1'b0}};
      for (int i = 0; i < DEF_WIDTH; i++) begin
         if (int'(idx) == (DEF_WIDTH - 1 - i)) begin
            vec[i] = 1'b1;
         end else begin
            vec[i] = 1'b0;
         end
      end
      return vec;
   endfunction

endpackage

// File: rtl/prio_idx_fifo.sv
// DEPTH x IDX_W index buffer. Pushes are ignored while full and pops while
// empty, so callers may drive wr_en/rd_en without gating. Occupancy, full
// and empty are kept as registers so they can feed top-level outputs.
module prio_idx_fifo
   import priority_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int IDX_W = DEF_IDX_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [IDX_W-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [IDX_W-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [IDX_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             full_r;
   logic             empty_r;

   logic             do_push_s;
   logic             do_pop_s;
   logic [CNT_W-1:0] count_nxt_s;

   // Qualify requests against the registered state and compute next occupancy
   always_comb begin
      do_push_s   = wr_en && !full_r;
      do_pop_s    = rd_en && !empty_r;
      count_nxt_s = count_r;
      case ({do_push_s, do_pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointers and occupancy flags; reset discards contents by rewinding
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= CNT_ZERO;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == CNT_FULL);
         empty_r <= (count_nxt_s == CNT_ZERO);
      end
   end

   // Storage array; stale entries are harmless once the pointers rewind
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_ptr_r];
   assign count   = count_r;
   assign full    = full_r;
   assign empty   = empty_r;

endmodule

// File: rtl/priority_dec.sv
// Registered priority decoder: buffers encoded indices without backpressure,
// turns each back into a one-hot request vector and presents it on a
// ready/valid output register. Indices arriving while the buffer is full are
// dropped and recorded in a sticky overflow flag.
module priority_dec
   import priority_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDX_W = $clog2(WIDTH),
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [IDX_W-1:0]         Y,
   input  logic                     valid,
   output logic [WIDTH-1:0]         out_d,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   logic [IDX_W-1:0] head_s;
   logic             empty_s;
   logic             full_s;
   logic             load_s;
   logic [WIDTH-1:0] dec_s;

   logic [WIDTH-1:0] out_d_r;
   logic             out_valid_r;
   logic             overflow_r;

   prio_idx_fifo #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (valid),
      .wr_data (Y),
      .rd_en   (load_s),
      .rd_data (head_s),
      .count   (count),
      .full    (full_s),
      .empty   (empty_s)
   );

   // Decide whether the head moves into the output register this edge
   always_comb begin
      if (!empty_s && (!out_valid_r || out_ready)) begin
         load_s = 1'b1;
      end else begin
         load_s = 1'b0;
      end
   end

   // Head index to one-hot: index WIDTH-1 lands on bit 0 (highest priority)
   always_comb begin
      dec_s = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         if (int'(head_s) == (WIDTH - 1 - i)) begin
            dec_s[i] = 1'b1;
         end else begin
            dec_s[i] = 1'b0;
         end
      end
   end

   // Output register: load, drain to zero when accepted with nothing behind, else hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_d_r     <= {WIDTH{1'b0}};
         out_valid_r <= 1'b0;
      end else if (load_s) begin
         out_d_r     <= dec_s;
         out_valid_r <= 1'b1;
      end else if (out_valid_r && out_ready) begin
         out_d_r     <= {WIDTH{1'b0}};
         out_valid_r <= 1'b0;
      end
   end

   // Sticky drop flag; full is the pre-edge value so a same-edge pop cannot rescue the sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_r <= 1'b0;
      end else if (valid && full_s) begin
         overflow_r <= 1'b1;
      end
   end

   assign out_d     = out_d_r;
   assign out_valid = out_valid_r;
   assign overflow  = overflow_r;
   assign full      = full_s;

endmodule

// File: tb/tb_priority_dec.sv
// Directed bench for priority_dec (WIDTH=4, DEPTH=4) plus a randomised
// wrap-around stream checked against a small queue model.
module tb_priority_dec;
   import priority_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] Y;
   logic       valid;
   logic [3:0] out_d;
   logic       out_valid;
   logic       out_ready;
   logic       full;
   logic [2:0] count;
   logic       overflow;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   priority_dec #(.WIDTH(4), .IDX_W(2), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .Y         (Y),
      .valid     (valid),
      .out_d     (out_d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .full      (full),
      .count     (count),
      .overflow  (overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; valid = 1'b1; Y = 2'd2; out_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++;
         if ({out_valid, out_d, count, overflow, full} !== 10'b0) begin
            tests_failed++;
            $display("FAIL reset_hold cyc=%0d got v=%b d=%b cnt=%0d ov=%b full=%b want all 0",
                     i, out_valid, out_d, count, overflow, full);
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         Y = 2'(i); valid = 1'b1;
         tick();
      end
      valid = 1'b0;
      tests_run++;
      if (count !== 3'd3 || out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_prefill got cnt=%0d v=%b want cnt=3 v=1", count, out_valid);
      end
      #2;
      rst = 1'b1;
      #1;
      tests_run++;
      if ({out_valid, out_d, count, overflow, full} !== 10'b0) begin
         tests_failed++;
         $display("FAIL reset_async got v=%b d=%b cnt=%0d ov=%b full=%b want all 0",
                  out_valid, out_d, count, overflow, full);
      end
      rst = 1'b0;
      tick();
      tests_run++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_after got cnt=%0d v=%b want cnt=0 v=0", count, out_valid);
      end
   endtask

   task automatic test_mapping();
      logic [1:0] ys [4];
      logic [3:0] ex [4];
      ys = '{2'd3, 2'd2, 2'd1, 2'd0};
      ex = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         Y = ys[i]; valid = 1'b1;
         tick();
         if (i > 0) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_d !== ex[i-1]) begin
               tests_failed++;
               $display("FAIL map_Y%0d got v=%b d=%b want v=1 d=%b", ys[i-1], out_valid, out_d, ex[i-1]);
            end
         end
      end
      valid = 1'b0;
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_d !== ex[3]) begin
         tests_failed++;
         $display("FAIL map_Y0 got v=%b d=%b want v=1 d=%b", out_valid, out_d, ex[3]);
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || out_d !== 4'b0000) begin
         tests_failed++;
         $display("FAIL map_drain got v=%b d=%b want v=0 d=0000", out_valid, out_d);
      end
      Y = 2'd1;
      tick();
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
         tests_failed++;
         $display("FAIL map_idle got v=%b cnt=%0d want v=0 cnt=0", out_valid, count);
      end
   endtask

   task automatic test_backpressure();
      logic [1:0] bp [5];
      bp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         Y = bp[i]; valid = 1'b1;
         tick();
         if (i == 1) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_d !== 4'b1000) begin
               tests_failed++;
               $display("FAIL bp_first got v=%b d=%b want v=1 d=1000", out_valid, out_d);
            end
         end
      end
      tests_run++;
      if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0 || out_d !== 4'b1000) begin
         tests_failed++;
         $display("FAIL bp_full got cnt=%0d full=%b ov=%b d=%b want cnt=4 full=1 ov=0 d=1000",
                  count, full, overflow, out_d);
      end
      Y = 2'd1; valid = 1'b1;
      tick();
      valid = 1'b0;
      tests_run++;
      if (overflow !== 1'b1 || count !== 3'd4 || out_d !== 4'b1000) begin
         tests_failed++;
         $display("FAIL bp_drop got ov=%b cnt=%0d d=%b want ov=1 cnt=4 d=1000", overflow, count, out_d);
      end
   endtask

   task automatic test_drain();
      logic [3:0] dr [4];
      dr = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         tests_run++;
         if (out_valid !== 1'b1 || out_d !== dr[i]) begin
            tests_failed++;
            $display("FAIL drain_%0d got v=%b d=%b want v=1 d=%b", i, out_valid, out_d, dr[i]);
         end
         if (i == 0) begin
            tests_run++;
            if (count !== 3'd3 || full !== 1'b0) begin
               tests_failed++;
               $display("FAIL drain_unfull got cnt=%0d full=%b want cnt=3 full=0", count, full);
            end
         end
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || out_d !== 4'b0000 || count !== 3'd0 || full !== 1'b0 || overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL drain_end got v=%b d=%b cnt=%0d full=%b ov=%b want v=0 d=0000 cnt=0 full=0 ov=1",
                  out_valid, out_d, count, full, overflow);
      end
   endtask

   task automatic test_simultaneous();
      logic [1:0] ins  [6];
      logic [3:0] expo [6];
      logic [3:0] tail [2];
      ins  = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      expo = '{4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010};
      tail = '{4'b0001, 4'b1000};
      pulse_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         Y = 2'(i); valid = 1'b1;
         tick();
      end
      tests_run++;
      if (count !== 3'd2 || out_valid !== 1'b1 || out_d !== 4'b1000) begin
         tests_failed++;
         $display("FAIL sim_setup got cnt=%0d v=%b d=%b want cnt=2 v=1 d=1000", count, out_valid, out_d);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         Y = ins[i]; valid = 1'b1;
         tick();
         tests_run++;
         if (count !== 3'd2 || out_valid !== 1'b1 || out_d !== expo[i]) begin
            tests_failed++;
            $display("FAIL sim_%0d got cnt=%0d v=%b d=%b want cnt=2 v=1 d=%b", i, count, out_valid, out_d, expo[i]);
         end
      end
      valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         tests_run++;
         if (out_valid !== 1'b1 || out_d !== tail[i]) begin
            tests_failed++;
            $display("FAIL sim_tail%0d got v=%b d=%b want v=1 d=%b", i, out_valid, out_d, tail[i]);
         end
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL sim_end got v=%b cnt=%0d ov=%b want v=0 cnt=0 ov=0", out_valid, count, overflow);
      end
   endtask

   task automatic test_wrap();
      logic [1:0] mq   [$];
      logic [1:0] expq [$];
      logic [3:0] got  [$];
      logic       m_valid;
      logic [1:0] m_out;
      logic       m_ov;
      logic       v;
      logic       rdy;
      logic [1:0] y;
      logic       pop;
      logic       push;
      logic [3:0] m_d;
      int         pushes;
      int         cyc;
      m_valid = 1'b0; m_out = 2'd0; m_ov = 1'b0; pushes = 0; cyc = 0;
      pulse_reset();
      while (cyc < 200 && (pushes < 12 || m_valid || mq.size() > 0)) begin
         if (pushes < 12) begin
            v   = ($urandom_range(0, 3) != 0);
            y   = 2'($urandom_range(0, 3));
            rdy = ($urandom_range(0, 2) == 0);
         end else begin
            v   = 1'b0;
            y   = 2'd0;
            rdy = 1'b1;
         end
         if (v) pushes++;
         valid = v; Y = y; out_ready = rdy;
         if (out_valid && rdy) got.push_back(out_d);
         pop  = (mq.size() > 0) && (!m_valid || rdy);
         push = v && (mq.size() < 4);
         if (v && mq.size() == 4) m_ov = 1'b1;
         if (pop) begin
            m_out   = mq.pop_front();
            m_valid = 1'b1;
         end else if (m_valid && rdy) begin
            m_valid = 1'b0;
         end
         if (push) begin
            mq.push_back(y);
            expq.push_back(y);
         end
         tick();
         cyc++;
         m_d = m_valid ? (4'b1000 >> m_out) : 4'b0000;
         tests_run++;
         if (out_valid !== m_valid || out_d !== m_d || count !== 3'(mq.size()) || overflow !== m_ov) begin
            tests_failed++;
            $display("FAIL wrap_cyc%0d got v=%b d=%b cnt=%0d ov=%b want v=%b d=%b cnt=%0d ov=%b",
                     cyc, out_valid, out_d, count, overflow, m_valid, m_d, mq.size(), m_ov);
         end
      end
      valid = 1'b0;
      tests_run++;
      if (m_valid || mq.size() != 0 || got.size() != expq.size()) begin
         tests_failed++;
         $display("FAIL wrap_count got %0d outputs want %0d (model left v=%b q=%0d)",
                  got.size(), expq.size(), m_valid, mq.size());
      end
      for (int i = 0; i < got.size() && i < expq.size(); i++) begin
         tests_run++;
         if (got[i] !== idx_to_onehot(expq[i])) begin
            tests_failed++;
            $display("FAIL wrap_order%0d got d=%b want d=%b", i, got[i], idx_to_onehot(expq[i]));
         end
      end
   endtask

   initial begin
      test_reset();
      test_mapping();
      test_backpressure();
      test_drain();
      test_simultaneous();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
